// File: rtl/mm_pkg.sv
// Shared types and helpers for the n x n streaming matrix-multiply engine.
// Holds the FSM state type, the default buffer geometry and the size-clamp helper.
package mm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_A,
    ST_LOAD_B,
    ST_MAC,
    ST_SEND,
    ST_FIN
  } state_t;

  localparam int unsigned DEF_MAX_N = 4;
  localparam int unsigned BUF_DEPTH = DEF_MAX_N * DEF_MAX_N;

  function automatic int unsigned buf_depth(input int unsigned max_n);
    return max_n * max_n;
  endfunction

  // A zero or oversized request runs at the largest supported size.
  function automatic int unsigned clamp_n(input int unsigned n, input int unsigned max_n);
    return ((n == 0) || (n > max_n)) ? max_n : n;
  endfunction

endpackage

// File: rtl/mm_nxn_stream_if.sv
// Operand (ss_*) and result (sm_*) AXI-Stream channels of the matrix engine.
// The slave modport is the engine's view; master is the DMA/bench side.
interface mm_nxn_stream_if #(
  parameter int unsigned pDATA_WIDTH = 32
) ();

  logic                   ss_tvalid;
  logic                   ss_tready;
  logic [pDATA_WIDTH-1:0] ss_tdata;
  logic                   sm_tvalid;
  logic                   sm_tready;
  logic [pDATA_WIDTH-1:0] sm_tdata;
  logic                   sm_tlast;

  modport slave (
    input  ss_tvalid, ss_tdata, sm_tready,
    output ss_tready, sm_tvalid, sm_tdata, sm_tlast
  );

  modport master (
    output ss_tvalid, ss_tdata, sm_tready,
    input  ss_tready, sm_tvalid, sm_tdata, sm_tlast
  );

endinterface

// File: rtl/mm_opbuf.sv
// Operand register file: synchronous write, combinational read, one shared address.
// Contents are not reset; every location is written before it is read.
module mm_opbuf
  import mm_pkg::*;
#(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned DEPTH = BUF_DEPTH,
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mm_nxn_stream.sv
// Streaming C = A x B engine for runtime size n (1..MAX_N), modulo 2^pDATA_WIDTH.
// A then B arrive row-major on ss_*; C leaves row-major on sm_* with sm_tlast on the final element.
module mm_nxn_stream
  import mm_pkg::*;
#(
  parameter  int unsigned pDATA_WIDTH = 32,
  parameter  int unsigned MAX_N       = DEF_MAX_N,
  localparam int unsigned NW          = $clog2(MAX_N + 1)
) (
  input  logic          axis_clk,
  input  logic          axis_rst_n,
  input  logic          mm_start,
  input  logic [NW-1:0] mm_n,
  output logic          mm_done,
  output logic          mm_idle,
  mm_nxn_stream_if.slave axis
);

  localparam int unsigned DEPTH = buf_depth(MAX_N);
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] ROW_STRIDE = AW'(MAX_N);

  typedef logic [pDATA_WIDTH-1:0] word_t;

  state_t        state, state_nxt;
  logic [NW-1:0] n_r, n_nxt;
  logic [NW-1:0] row, row_nxt, col, col_nxt;
  logic [NW-1:0] i_r, i_nxt, j_r, j_nxt, k_r, k_nxt;
  word_t         acc, acc_nxt;
  word_t         tdata_r, tdata_nxt;
  logic          tlast_r, tlast_nxt;

  logic [NW-1:0] n_last;
  logic          beat;
  logic [AW-1:0] ld_addr, a_mac_addr, b_mac_addr, addr_a, addr_b;
  logic          we_a, we_b;
  word_t         a_rd, b_rd, prod;

  assign n_last = n_r - NW'(1);
  assign beat   = axis.ss_tvalid & axis.ss_tready;

  // Buffers are laid out with a fixed MAX_N stride regardless of the runtime n.
  assign ld_addr    = AW'(row) * ROW_STRIDE + AW'(col);
  assign a_mac_addr = AW'(i_r) * ROW_STRIDE + AW'(k_r);
  assign b_mac_addr = AW'(k_r) * ROW_STRIDE + AW'(j_r);

  assign addr_a = (state == ST_LOAD_A) ? ld_addr : a_mac_addr;
  assign addr_b = (state == ST_LOAD_B) ? ld_addr : b_mac_addr;
  assign we_a   = beat && (state == ST_LOAD_A);
  assign we_b   = beat && (state == ST_LOAD_B);

  mm_opbuf #(.WIDTH(pDATA_WIDTH), .DEPTH(DEPTH)) u_buf_a (
    .clk   (axis_clk),
    .we    (we_a),
    .addr  (addr_a),
    .wdata (axis.ss_tdata),
    .rdata (a_rd)
  );

  mm_opbuf #(.WIDTH(pDATA_WIDTH), .DEPTH(DEPTH)) u_buf_b (
    .clk   (axis_clk),
    .we    (we_b),
    .addr  (addr_b),
    .wdata (axis.ss_tdata),
    .rdata (b_rd)
  );

  assign prod = a_rd * b_rd;

  assign axis.ss_tready = (state == ST_LOAD_A) || (state == ST_LOAD_B);
  assign axis.sm_tvalid = (state == ST_SEND);
  assign axis.sm_tdata  = tdata_r;
  assign axis.sm_tlast  = tlast_r;
  assign mm_done        = (state == ST_FIN);
  assign mm_idle        = (state == ST_IDLE);

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state   <= ST_IDLE;
      n_r     <= '0;
      row     <= '0;
      col     <= '0;
      i_r     <= '0;
      j_r     <= '0;
      k_r     <= '0;
      acc     <= '0;
      tdata_r <= '0;
      tlast_r <= 1'b0;
    end else begin
      state   <= state_nxt;
      n_r     <= n_nxt;
      row     <= row_nxt;
      col     <= col_nxt;
      i_r     <= i_nxt;
      j_r     <= j_nxt;
      k_r     <= k_nxt;
      acc     <= acc_nxt;
      tdata_r <= tdata_nxt;
      tlast_r <= tlast_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    n_nxt     = n_r;
    row_nxt   = row;
    col_nxt   = col;
    i_nxt     = i_r;
    j_nxt     = j_r;
    k_nxt     = k_r;
    acc_nxt   = acc;
    tdata_nxt = tdata_r;
    tlast_nxt = tlast_r;

    case (state)
      ST_IDLE: begin
        if (mm_start) begin
          n_nxt     = NW'(clamp_n(32'(mm_n), MAX_N));
          row_nxt   = '0;
          col_nxt   = '0;
          state_nxt = ST_LOAD_A;
        end
      end

      ST_LOAD_A, ST_LOAD_B: begin
        if (beat) begin
          if (col == n_last) begin
            col_nxt = '0;
            if (row == n_last) begin
              row_nxt = '0;
              if (state == ST_LOAD_A) begin
                state_nxt = ST_LOAD_B;
              end else begin
                state_nxt = ST_MAC;
                i_nxt     = '0;
                j_nxt     = '0;
                k_nxt     = '0;
                acc_nxt   = '0;
              end
            end else begin
              row_nxt = row + NW'(1);
            end
          end else begin
            col_nxt = col + NW'(1);
          end
        end
      end

      // The final product is folded straight into the output register so the
      // result is valid on the cycle right after the last multiply.
      ST_MAC: begin
        acc_nxt = acc + prod;
        if (k_r == n_last) begin
          k_nxt     = '0;
          tdata_nxt = acc + prod;
          tlast_nxt = (i_r == n_last) && (j_r == n_last);
          state_nxt = ST_SEND;
        end else begin
          k_nxt = k_r + NW'(1);
        end
      end

      ST_SEND: begin
        if (axis.sm_tready) begin
          tlast_nxt = 1'b0;
          acc_nxt   = '0;
          if (tlast_r) begin
            state_nxt = ST_FIN;
          end else begin
            state_nxt = ST_MAC;
            if (j_r == n_last) begin
              j_nxt = '0;
              i_nxt = i_r + NW'(1);
            end else begin
              j_nxt = j_r + NW'(1);
            end
          end
        end
      end

      ST_FIN: begin
        i_nxt     = '0;
        j_nxt     = '0;
        state_nxt = ST_IDLE;
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mm_nxn_stream.sv
// Directed bench for mm_nxn_stream: hand-computed products, stalls, ignored starts and mid-run reset.
module tb_mm_nxn_stream;

  logic       clk;
  logic       rst_n;
  logic       mm_start;
  logic [2:0] mm_n;
  logic       mm_done;
  logic       mm_idle;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int beat_cyc = 0;

  logic [31:0] ops[$];
  logic [31:0] exp_q[$];

  mm_nxn_stream_if #(.pDATA_WIDTH(32)) axis ();

  mm_nxn_stream #(.pDATA_WIDTH(32), .MAX_N(4)) dut (
    .axis_clk   (clk),
    .axis_rst_n (rst_n),
    .mm_start   (mm_start),
    .mm_n       (mm_n),
    .mm_done    (mm_done),
    .mm_idle    (mm_idle),
    .axis       (axis)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Streams operands; optionally inserts random gaps and pokes mm_start in LOAD_B and SEND.
  task automatic drive(input logic [31:0] q[$], input bit gaps, input bit poke);
    int t;
    for (int b = 0; b < q.size(); b++) begin
      if (gaps) begin
        axis.ss_tvalid = 1'b0;
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
      axis.ss_tvalid = 1'b1;
      axis.ss_tdata  = q[b];
      if (poke && (b == q.size() / 2 + 1)) mm_start = 1'b1;
      t = 0;
      @(negedge clk);
      while (!axis.ss_tready && t < 50) begin
        @(negedge clk);
        t++;
      end
      chk("ss_tready", 32'(axis.ss_tready), 32'd1);
      beat_cyc = cyc;
      @(posedge clk);
      #1;
      mm_start = 1'b0;
    end
    axis.ss_tvalid = 1'b0;
    if (poke) begin
      t = 0;
      @(negedge clk);
      while (!axis.sm_tvalid && t < 100) begin
        @(negedge clk);
        t++;
      end
      mm_start = 1'b1;
      @(negedge clk);
      mm_start = 1'b0;
    end
  endtask

  task automatic collect(input logic [31:0] ex[$], input int n, input bit stall);
    int t;
    int hs_cyc;
    logic last_e;
    hs_cyc = 0;
    axis.sm_tready = !stall;
    for (int e = 0; e < ex.size(); e++) begin
      t = 0;
      @(negedge clk);
      while (!axis.sm_tvalid && t < 300) begin
        @(negedge clk);
        t++;
      end
      chk("sm_tvalid_wait", 32'(axis.sm_tvalid), 32'd1);
      if (!axis.sm_tvalid) return;
      chk("latency", 32'(cyc - ((e == 0) ? beat_cyc : hs_cyc)), 32'(n + 1));
      chk("idle_busy", 32'(mm_idle), 32'd0);
      if (stall) begin
        repeat (5) begin
          chk("hold_data", axis.sm_tdata, ex[e]);
          chk("hold_valid", 32'(axis.sm_tvalid), 32'd1);
          @(negedge clk);
        end
        axis.sm_tready = 1'b1;
      end
      last_e = (e == ex.size() - 1);
      chk("tdata", axis.sm_tdata, ex[e]);
      chk("tlast", 32'(axis.sm_tlast), 32'(last_e));
      hs_cyc = cyc;
      @(posedge clk);
      #1;
      if (stall) axis.sm_tready = 1'b0;
    end
    @(negedge clk);
    chk("done_pulse", 32'(mm_done), 32'd1);
    chk("idle_fin", 32'(mm_idle), 32'd0);
    @(negedge clk);
    chk("done_clear", 32'(mm_done), 32'd0);
    chk("idle_back", 32'(mm_idle), 32'd1);
  endtask

  task automatic start_job(input logic [2:0] n_in);
    @(posedge clk);
    #1;
    chk("idle_pre", 32'(mm_idle), 32'd1);
    chk("ready_idle", 32'(axis.ss_tready), 32'd0);
    mm_n     = n_in;
    mm_start = 1'b1;
    @(posedge clk);
    #1;
    mm_start = 1'b0;
  endtask

  task automatic run_job(input logic [2:0] n_in, input int n_eff, input bit gaps,
                         input bit stall, input bit poke);
    start_job(n_in);
    fork
      drive(ops, gaps, poke);
      collect(exp_q, n_eff, stall);
    join
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    mm_start       = 1'b0;
    mm_n           = '0;
    axis.ss_tvalid = 1'b0;
    axis.ss_tdata  = '0;
    axis.sm_tready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_idle", 32'(mm_idle), 32'd1);
    chk("rst_done", 32'(mm_done), 32'd0);
    chk("rst_ss_tready", 32'(axis.ss_tready), 32'd0);
    chk("rst_sm_tvalid", 32'(axis.sm_tvalid), 32'd0);
    chk("rst_sm_tdata", axis.sm_tdata, 32'd0);
    chk("rst_sm_tlast", 32'(axis.sm_tlast), 32'd0);
    rst_n = 1'b1;

    // 2x2 basic product
    ops   = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
    exp_q = '{32'd19, 32'd22, 32'd43, 32'd50};
    run_job(3'd2, 2, 1'b0, 1'b0, 1'b0);

    // I3 x (1..9)
    ops   = '{32'd1, 32'd0, 32'd0, 32'd0, 32'd1, 32'd0, 32'd0, 32'd0, 32'd1,
              32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9};
    exp_q = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9};
    run_job(3'd3, 3, 1'b0, 1'b0, 1'b0);

    // n=0 clamps to 4: I4 x (1..16)
    ops.delete();
    exp_q.delete();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) ops.push_back((r == c) ? 32'd1 : 32'd0);
    for (int v = 1; v <= 16; v++) begin
      ops.push_back(32'(v));
      exp_q.push_back(32'(v));
    end
    run_job(3'd0, 4, 1'b0, 1'b0, 1'b0);

    // n=1 signed and wrap cases
    ops   = '{32'hFFFF_FFFF, 32'd7};
    exp_q = '{32'hFFFF_FFF9};
    run_job(3'd1, 1, 1'b0, 1'b0, 1'b0);
    ops   = '{32'h0001_0000, 32'h0001_0000};
    exp_q = '{32'h0000_0000};
    run_job(3'd1, 1, 1'b0, 1'b0, 1'b0);

    // 2x2 with input gaps, output stalls and ignored start pulses
    ops   = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
    exp_q = '{32'd19, 32'd22, 32'd43, 32'd50};
    run_job(3'd2, 2, 1'b1, 1'b1, 1'b1);

    // Reset during MAC, then a clean rerun
    start_job(3'd2);
    drive(ops, 1'b0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_sm_tvalid", 32'(axis.sm_tvalid), 32'd0);
    chk("arst_sm_tdata", axis.sm_tdata, 32'd0);
    chk("arst_sm_tlast", 32'(axis.sm_tlast), 32'd0);
    chk("arst_done", 32'(mm_done), 32'd0);
    chk("arst_idle", 32'(mm_idle), 32'd1);
    chk("arst_ss_tready", 32'(axis.ss_tready), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("post_rst_valid", 32'(axis.sm_tvalid), 32'd0);
      chk("post_rst_done", 32'(mm_done), 32'd0);
    end
    run_job(3'd2, 2, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
